// File: rtl/fifo_threshold_if.sv
// -----------------------------------------------------------------------------
// fifo_threshold_if
// Bundles the data/handshake/status signals of fifo_threshold.
//   master : the user of the FIFO (drives push/pop/data_in/thresholds)
//   slave  : the FIFO itself (drives data_out/valid_out/flags/count/error)
// Signals:
//   push, data_in       write request and write data
//   pop                 read request
//   umbral_hi/lo        almost-full / almost-empty thresholds
//   data_out, valid_out registered read data and its valid strobe
//   empty, full         occupancy == 0 / occupancy == depth
//   almost_empty/full   occupancy <= umbral_lo / occupancy >= umbral_hi
//   error               overflow / underflow indication
//   count               current occupancy (ADDR_WIDTH+1 bits)
// -----------------------------------------------------------------------------
interface fifo_threshold_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int U_WIDTH    = 4
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [U_WIDTH-1:0]    umbral_hi;
    logic [U_WIDTH-1:0]    umbral_lo;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  error;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output push, data_in, pop, umbral_hi, umbral_lo,
        input  data_out, valid_out, empty, full, almost_empty, almost_full,
               error, count
    );

    modport slave (
        input  push, data_in, pop, umbral_hi, umbral_lo,
        output data_out, valid_out, empty, full, almost_empty, almost_full,
               error, count
    );
endinterface

// File: rtl/fifo_threshold.sv
// -----------------------------------------------------------------------------
// fifo_threshold
// Circular-buffer FIFO of 2**ADDR_WIDTH words with occupancy count,
// programmable almost-empty / almost-full thresholds and an overflow /
// underflow error flag. Read data is registered (one-cycle latency).
//
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high; clears pointers, count, data_out,
//            valid_out and error
//   bus    : fifo_threshold_if.slave (see interface file for signal list)
//
// Parameters:
//   DATA_WIDTH : word width
//   ADDR_WIDTH : pointer width, depth = 2**ADDR_WIDTH
//   U_WIDTH    : threshold width, must be >= ADDR_WIDTH+1
//
// Build option:
//   FIFO_STICKY_ERROR_EN defined   : error latches to 1 after the first
//                                    overflow/underflow until reset
//   FIFO_STICKY_ERROR_EN undefined : error is a one-cycle pulse after each
//                                    overflow/underflow
// -----------------------------------------------------------------------------
module fifo_threshold #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int U_WIDTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    fifo_threshold_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_q;
    logic                  error_q, error_d;

    logic                  is_empty;
    logic                  is_full;
    logic                  do_push;
    logic                  do_pop;
    logic                  overflow;
    logic                  underflow;
    logic [U_WIDTH-1:0]    count_ext;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // A pop succeeds whenever there is something to read. A push succeeds when
    // there is room, or when a same-cycle pop frees the slot of a full FIFO.
    // An empty FIFO never lets a push "feed" a same-cycle pop.
    assign do_pop    = bus.pop && !is_empty;
    assign do_push   = bus.push && (!is_full || do_pop);
    assign overflow  = bus.push && is_full && !bus.pop;
    assign underflow = bus.pop && is_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

`ifdef FIFO_STICKY_ERROR_EN
    assign error_d = error_q || overflow || underflow;
`else
    assign error_d = overflow || underflow;
`endif

    // Storage: no reset so it maps onto RAM; contents after reset are
    // don't-care because both pointers restart at zero.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
            valid_q  <= do_pop;
            // Full FIFO with push+pop: write and read hit the same slot; the
            // read sees the old word because the write lands at the same edge.
            if (do_pop) begin
                data_out_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Zero-extend the count to the threshold width for unsigned compares.
    genvar gi;
    generate
        for (gi = 0; gi < U_WIDTH; gi++) begin : g_count_ext
            if (gi < CW) begin : g_bit
                assign count_ext[gi] = count_q[gi];
            end else begin : g_zero
                assign count_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = (count_ext <= bus.umbral_lo);
    assign bus.almost_full  = (count_ext >= bus.umbral_hi);
    assign bus.count        = count_q;
    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_q;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_fifo_threshold.sv
// -----------------------------------------------------------------------------
// tb_fifo_threshold
// Directed, table-driven bench for fifo_threshold (default parameters:
// 6-bit data, depth 4, 4-bit thresholds). Each table row is one clock cycle
// of stimulus plus the outputs expected just after that edge. Error
// expectations are written as per-cycle pulses; a sticky build accumulates
// them until the next reset row. A hand-written streaming sequence follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_threshold;
    localparam int DW = 6;
    localparam int AW = 2;
    localparam int UW = 4;
    localparam int NV = 43;

    logic clk;
    logic reset;

    fifo_threshold_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .U_WIDTH(UW)) bus ();

    fifo_threshold #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .U_WIDTH(UW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          push;
        logic          pop;
        logic [DW-1:0] din;
        logic [UW-1:0] hi;
        logic [UW-1:0] lo;
        logic [AW:0]   cnt;
        logic          em;
        logic          fu;
        logic          ae;
        logic          af;
        logic          vo;
        logic [DW-1:0] dout;
        logic          err;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic sticky_exp;

    function automatic vec_t mk(
        input logic rst, input logic push, input logic pop, input logic [DW-1:0] din,
        input logic [UW-1:0] hi, input logic [UW-1:0] lo,
        input logic [AW:0] cnt, input logic em, input logic fu, input logic ae,
        input logic af, input logic vo, input logic [DW-1:0] dout, input logic err);
        vec_t v;
        v.rst = rst; v.push = push; v.pop = pop; v.din = din; v.hi = hi; v.lo = lo;
        v.cnt = cnt; v.em = em; v.fu = fu; v.ae = ae; v.af = af; v.vo = vo;
        v.dout = dout; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic [AW:0] cnt,
        input logic em, input logic fu, input logic ae, input logic af,
        input logic vo, input logic [DW-1:0] dout, input logic err_exp);
        chk("count",        idx, 32'(bus.count),        32'(cnt));
        chk("empty",        idx, 32'(bus.empty),        32'(em));
        chk("full",         idx, 32'(bus.full),         32'(fu));
        chk("almost_empty", idx, 32'(bus.almost_empty), 32'(ae));
        chk("almost_full",  idx, 32'(bus.almost_full),  32'(af));
        chk("valid_out",    idx, 32'(bus.valid_out),    32'(vo));
        chk("data_out",     idx, 32'(bus.data_out),     32'(dout));
        chk("error",        idx, 32'(bus.error),        32'(err_exp));
    endtask

    task automatic drive(input logic rst, input logic push, input logic pop,
                         input logic [DW-1:0] din, input logic [UW-1:0] hi,
                         input logic [UW-1:0] lo);
        @(negedge clk);
        reset         = rst;
        bus.push      = push;
        bus.pop       = pop;
        bus.data_in   = din;
        bus.umbral_hi = hi;
        bus.umbral_lo = lo;
        @(posedge clk);
        #1;
    endtask

    function automatic logic err_model(input logic rst, input logic pulse);
`ifdef FIFO_STICKY_ERROR_EN
        if (rst) sticky_exp = 1'b0;
        else     sticky_exp = sticky_exp | pulse;
        return sticky_exp;
`else
        return rst ? 1'b0 : pulse;
`endif
    endfunction

    initial begin
        logic          e;
        logic [DW-1:0] exp_d;
        sticky_exp    = 1'b0;
        reset         = 1'b1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.data_in   = '0;
        bus.umbral_hi = 4'd4;
        bus.umbral_lo = 4'd0;

        //            rst psh pop din    hi lo  cnt em fu ae af vo dout   err
        // reset
        vecs[0]  = mk(1, 0, 0, 6'h00, 4, 0, 0, 1, 0, 1, 0, 0, 6'h00, 0);
        // fill with 01..04
        vecs[1]  = mk(0, 1, 0, 6'h01, 4, 0, 1, 0, 0, 0, 0, 0, 6'h00, 0);
        vecs[2]  = mk(0, 1, 0, 6'h02, 4, 0, 2, 0, 0, 0, 0, 0, 6'h00, 0);
        vecs[3]  = mk(0, 1, 0, 6'h03, 4, 0, 3, 0, 0, 0, 0, 0, 6'h00, 0);
        vecs[4]  = mk(0, 1, 0, 6'h04, 4, 0, 4, 0, 1, 0, 1, 0, 6'h00, 0);
        // drain: data one cycle after each pop
        vecs[5]  = mk(0, 0, 1, 6'h00, 4, 0, 3, 0, 0, 0, 0, 1, 6'h01, 0);
        vecs[6]  = mk(0, 0, 1, 6'h00, 4, 0, 2, 0, 0, 0, 0, 1, 6'h02, 0);
        vecs[7]  = mk(0, 0, 1, 6'h00, 4, 0, 1, 0, 0, 0, 0, 1, 6'h03, 0);
        vecs[8]  = mk(0, 0, 1, 6'h00, 4, 0, 0, 1, 0, 1, 0, 1, 6'h04, 0);
        vecs[9]  = mk(0, 0, 0, 6'h00, 4, 0, 0, 1, 0, 1, 0, 0, 6'h04, 0);
        // overflow: fill, push 3F while full
        vecs[10] = mk(0, 1, 0, 6'h01, 4, 0, 1, 0, 0, 0, 0, 0, 6'h04, 0);
        vecs[11] = mk(0, 1, 0, 6'h02, 4, 0, 2, 0, 0, 0, 0, 0, 6'h04, 0);
        vecs[12] = mk(0, 1, 0, 6'h03, 4, 0, 3, 0, 0, 0, 0, 0, 6'h04, 0);
        vecs[13] = mk(0, 1, 0, 6'h04, 4, 0, 4, 0, 1, 0, 1, 0, 6'h04, 0);
        vecs[14] = mk(0, 1, 0, 6'h3F, 4, 0, 4, 0, 1, 0, 1, 0, 6'h04, 1);
        vecs[15] = mk(0, 0, 0, 6'h00, 4, 0, 4, 0, 1, 0, 1, 0, 6'h04, 0);
        vecs[16] = mk(0, 0, 1, 6'h00, 4, 0, 3, 0, 0, 0, 0, 1, 6'h01, 0);
        vecs[17] = mk(0, 0, 1, 6'h00, 4, 0, 2, 0, 0, 0, 0, 1, 6'h02, 0);
        vecs[18] = mk(0, 0, 1, 6'h00, 4, 0, 1, 0, 0, 0, 0, 1, 6'h03, 0);
        vecs[19] = mk(0, 0, 1, 6'h00, 4, 0, 0, 1, 0, 1, 0, 1, 6'h04, 0);
        // full with simultaneous push 2A + pop, then drain across the wrap
        vecs[20] = mk(0, 1, 0, 6'h01, 4, 0, 1, 0, 0, 0, 0, 0, 6'h04, 0);
        vecs[21] = mk(0, 1, 0, 6'h02, 4, 0, 2, 0, 0, 0, 0, 0, 6'h04, 0);
        vecs[22] = mk(0, 1, 0, 6'h03, 4, 0, 3, 0, 0, 0, 0, 0, 6'h04, 0);
        vecs[23] = mk(0, 1, 0, 6'h04, 4, 0, 4, 0, 1, 0, 1, 0, 6'h04, 0);
        vecs[24] = mk(0, 1, 1, 6'h2A, 4, 0, 4, 0, 1, 0, 1, 1, 6'h01, 0);
        vecs[25] = mk(0, 0, 1, 6'h00, 4, 0, 3, 0, 0, 0, 0, 1, 6'h02, 0);
        vecs[26] = mk(0, 0, 1, 6'h00, 4, 0, 2, 0, 0, 0, 0, 1, 6'h03, 0);
        vecs[27] = mk(0, 0, 1, 6'h00, 4, 0, 1, 0, 0, 0, 0, 1, 6'h04, 0);
        vecs[28] = mk(0, 0, 1, 6'h00, 4, 0, 0, 1, 0, 1, 0, 1, 6'h2A, 0);
        // underflow on empty: data_out holds, valid_out low
        vecs[29] = mk(0, 0, 1, 6'h00, 4, 0, 0, 1, 0, 1, 0, 0, 6'h2A, 1);
        vecs[30] = mk(0, 0, 0, 6'h00, 4, 0, 0, 1, 0, 1, 0, 0, 6'h2A, 0);
        vecs[31] = mk(1, 0, 0, 6'h00, 4, 0, 0, 1, 0, 1, 0, 0, 6'h00, 0);
        // push+pop while empty: push lands, pop underflows
        vecs[32] = mk(0, 1, 1, 6'h11, 4, 0, 1, 0, 0, 0, 0, 0, 6'h00, 1);
        vecs[33] = mk(0, 0, 0, 6'h00, 4, 0, 1, 0, 0, 0, 0, 0, 6'h00, 0);
        // thresholds hi=3 lo=1
        vecs[34] = mk(1, 0, 0, 6'h00, 3, 1, 0, 1, 0, 1, 0, 0, 6'h00, 0);
        vecs[35] = mk(0, 1, 0, 6'h05, 3, 1, 1, 0, 0, 1, 0, 0, 6'h00, 0);
        vecs[36] = mk(0, 1, 0, 6'h06, 3, 1, 2, 0, 0, 0, 0, 0, 6'h00, 0);
        vecs[37] = mk(0, 1, 0, 6'h07, 3, 1, 3, 0, 0, 0, 1, 0, 6'h00, 0);
        vecs[38] = mk(0, 0, 1, 6'h00, 3, 1, 2, 0, 0, 0, 0, 1, 6'h05, 0);
        // reset wins over a push at count 2
        vecs[39] = mk(1, 1, 0, 6'h09, 3, 1, 0, 1, 0, 1, 0, 0, 6'h00, 0);
        // umbral_hi=0 -> almost_full always; umbral_lo>=depth -> almost_empty always
        vecs[40] = mk(0, 0, 0, 6'h00, 0, 1, 0, 1, 0, 1, 1, 0, 6'h00, 0);
        vecs[41] = mk(0, 1, 0, 6'h0A, 0, 15, 1, 0, 0, 1, 1, 0, 6'h00, 0);
        vecs[42] = mk(0, 1, 0, 6'h0B, 0, 4, 2, 0, 0, 1, 1, 0, 6'h00, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].din,
                  vecs[i].hi, vecs[i].lo);
            e = err_model(vecs[i].rst, vecs[i].err);
            $display("step %0d: rst=%0b push=%0b pop=%0b din=%0h -> count=%0d dout=%0h valid=%0b err=%0b",
                     i, vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].din,
                     bus.count, bus.data_out, bus.valid_out, bus.error);
            check_outputs(i, vecs[i].cnt, vecs[i].em, vecs[i].fu, vecs[i].ae,
                          vecs[i].af, vecs[i].vo, vecs[i].dout, e);
        end

        // Streaming at count 2 with simultaneous push+pop: count holds and
        // words come out in order across several pointer wraps.
        drive(1, 0, 0, 6'h00, 4, 0);
        e = err_model(1, 0);
        drive(0, 1, 0, 6'h15, 4, 0);
        drive(0, 1, 0, 6'h16, 4, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 1, 6'(32'h20 + i), 4, 0);
            if (i == 0)      exp_d = 6'h15;
            else if (i == 1) exp_d = 6'h16;
            else             exp_d = 6'(32'h20 + i - 2);
            e = err_model(0, 0);
            $display("stream %0d: push=%0h -> count=%0d dout=%0h valid=%0b",
                     i, 6'(32'h20 + i), bus.count, bus.data_out, bus.valid_out);
            check_outputs(100 + i, 3'd2, 0, 0, 0, 0, 1, exp_d, e);
        end
        drive(0, 0, 1, 6'h00, 4, 0);
        $display("stream drain: count=%0d dout=%0h", bus.count, bus.data_out);
        check_outputs(108, 3'd1, 0, 0, 0, 0, 1, 6'h26, e);
        drive(0, 0, 1, 6'h00, 4, 0);
        $display("stream drain: count=%0d dout=%0h", bus.count, bus.data_out);
        check_outputs(109, 3'd0, 1, 0, 1, 0, 1, 6'h27, e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
